// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
// Optional build macro used by the arbiter: SRAM_ARB_RR_EN (round-robin IDLE tie-break).
package sram_arb_pkg;

    localparam int unsigned BEN_W  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned MASK_W = BEN_W * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Byte-enable patterns the SRAM wrapper accepts: single byte, aligned half, full word
    function automatic logic ben_legal(input logic [BEN_W-1:0] ben);
        logic ok;
        case (ben)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Expand byte enables to a bit mask over the data word
    function automatic logic [MASK_W-1:0] ben_to_mask(input logic [BEN_W-1:0] ben);
        logic [MASK_W-1:0] mask;
        for (int unsigned i = 0; i < BEN_W; i++) begin
            mask[i*LANE_W +: LANE_W] = {LANE_W{ben[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for the two-port SRAM arbiter.
// Macro SRAM_ARB_RR_EN: when defined, an IDLE tie goes to the port that was not last owner.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic [1:0]        i_req,
    input  arb_state_e        i_state,
    input  logic [HOLD_W-1:0] i_hold_cnt,
    input  logic              i_last_owner,
    output logic              o_valid,
    output logic              o_sel
);

    logic w_idle_pick;
    logic w_hold_ok;

`ifdef SRAM_ARB_RR_EN
    assign w_idle_pick = ~i_last_owner;
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;
    assign w_idle_pick = 1'b0;
`endif

    assign w_hold_ok = (i_hold_cnt < HOLD_W'(MAX_HOLD));

    // Pick a winner: lone requester wins, ties resolved by state and hold budget
    always_comb begin
        o_valid = |i_req;
        o_sel   = 1'b0;
        if (i_req == 2'b10) begin
            o_sel = 1'b1;
        end else if (i_req == 2'b11) begin
            case (i_state)
                OWN0:    o_sel = w_hold_ok ? 1'b0 : 1'b1;
                OWN1:    o_sel = w_hold_ok ? 1'b1 : 1'b0;
                default: o_sel = w_idle_pick;
            endcase
        end
    end

endmodule

// File: rtl/sram_arb2.sv
// Two-requester arbiter in front of a byte-enabled SRAM with 1-cycle read latency.
// Port 0 is the CPU data side, port 1 the DMA/debug side.
// Macro SRAM_ARB_RR_EN selects round-robin instead of fixed priority for IDLE ties.
module sram_arb2
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_wr,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    input  logic [BEN_W-1:0] m0_ben,
    output logic             m0_gnt,
    output logic             m0_err,
    output logic             m0_rvalid,
    output logic [DW-1:0]    m0_rdata,
    input  logic             m1_req,
    input  logic             m1_wr,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    input  logic [BEN_W-1:0] m1_ben,
    output logic             m1_gnt,
    output logic             m1_err,
    output logic             m1_rvalid,
    output logic [DW-1:0]    m1_rdata,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    output logic [BEN_W-1:0] ram_ben,
    output logic             ram_wren,
    input  logic [DW-1:0]    ram_dout
);

    logic [1:0]        w_req;
    logic              w_valid;
    logic              w_sel;
    logic              w_wr;
    logic              w_legal;
    logic              w_same_owner;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_wdata;
    logic [BEN_W-1:0]  w_ben;
    logic [DW-1:0]     w_rd_data;

    arb_state_e        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_last_owner;
    logic [AW-1:0]     r_ram_addr;
    logic              r_rv0, r_rv1;
    logic              r_err0, r_err1;
    logic [DW-1:0]     r_rd_mask;
    logic [DW-1:0]     r_rdata0, r_rdata1;

    // No access is issued while reset is asserted
    assign w_req = {m1_req, m0_req} & {2{~rst}};

    sram_arb_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .i_req        (w_req),
        .i_state      (r_state),
        .i_hold_cnt   (r_hold_cnt),
        .i_last_owner (r_last_owner),
        .o_valid      (w_valid),
        .o_sel        (w_sel)
    );

    // Steer the winning port's request onto the shared path
    always_comb begin
        w_wr    = m0_wr;
        w_addr  = m0_addr;
        w_wdata = m0_wdata;
        w_ben   = m0_ben;
        if (w_sel) begin
            w_wr    = m1_wr;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
            w_ben   = m1_ben;
        end
    end

    assign w_legal      = ben_legal(w_ben);
    assign w_same_owner = w_sel ? (r_state == OWN1) : (r_state == OWN0);
    assign w_rd_data    = ram_dout & r_rd_mask;

    assign m0_gnt   = w_valid & ~w_sel;
    assign m1_gnt   = w_valid &  w_sel;
    assign ram_addr = w_valid ? w_addr : r_ram_addr;
    assign ram_din  = w_valid ? w_wdata : '0;
    assign ram_ben  = (w_valid & w_legal) ? w_ben : '0;
    assign ram_wren = w_valid & w_legal & w_wr;

    // Arbitration state, hold budget and one-deep response pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_last_owner <= 1'b1;
            r_ram_addr   <= '0;
            r_rv0        <= 1'b0;
            r_rv1        <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rd_mask    <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_valid) begin
                r_state      <= w_sel ? OWN1 : OWN0;
                r_last_owner <= w_sel;
                r_ram_addr   <= w_addr;
                if (!w_same_owner) begin
                    r_hold_cnt <= HOLD_W'(1);
                end else if (r_hold_cnt < HOLD_W'(MAX_HOLD)) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
            end else begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
            end
            r_rv0     <= m0_gnt & w_legal & ~w_wr;
            r_rv1     <= m1_gnt & w_legal & ~w_wr;
            r_err0    <= m0_gnt & ~w_legal;
            r_err1    <= m1_gnt & ~w_legal;
            r_rd_mask <= DW'(ben_to_mask(w_ben));
            if (r_rv0) r_rdata0 <= w_rd_data;
            if (r_rv1) r_rdata1 <= w_rd_data;
        end
    end

    // Read data comes straight from the SRAM output register on the valid cycle, then holds;
    // reset drops any in-flight response immediately
    assign m0_rvalid = r_rv0 & ~rst;
    assign m1_rvalid = r_rv1 & ~rst;
    assign m0_err    = r_err0 & ~rst;
    assign m1_err    = r_err1 & ~rst;
    assign m0_rdata  = m0_rvalid ? w_rd_data : r_rdata0;
    assign m1_rdata  = m1_rvalid ? w_rd_data : r_rdata1;

endmodule

// File: tb/tb_sram_arb2.sv
// Self-checking bench for sram_arb2: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter and SRAM.
module tb_sram_arb2;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_gnt, m0_err, m0_rvalid, m1_gnt, m1_err, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, ram_din, ram_dout;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_ben;
    logic        ram_wren;

    bit   req0 = 1'b0, req1 = 1'b0;
    req_t cur0 = '0, cur1 = '0;
    req_t q0[$], q1[$];
    bit   rand_en = 1'b0;
    bit   run_chk = 1'b0;
    int   exp_win = -1;
    int   tests = 0, fails = 0;

    logic [3:0] legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    always #5 clk = ~clk;

    sram_arb2 #(.AW(10), .DW(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req0), .m0_wr(cur0.wr), .m0_addr(cur0.addr), .m0_wdata(cur0.wdata), .m0_ben(cur0.ben),
        .m0_gnt(m0_gnt), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req1), .m1_wr(cur1.wr), .m1_addr(cur1.addr), .m1_wdata(cur1.wdata), .m1_ben(cur1.ben),
        .m1_gnt(m1_gnt), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_ben(ram_ben), .ram_wren(ram_wren),
        .ram_dout(ram_dout)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 | 32'(i);
    endfunction

    function automatic bit is_legal(input logic [3:0] b);
        for (int i = 0; i < 7; i++) if (legal_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] b);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wr    = 1'($urandom_range(0, 1));
        r.addr  = 10'($urandom_range(0, 15));
        r.wdata = $urandom;
        if ($urandom_range(0, 3) != 0) r.ben = legal_list[$urandom_range(0, 6)];
        else                           r.ben = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM behaviour seen by the DUT: byte-masked write, registered read
    logic [31:0] env_mem [1024];
    bit env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_ben[b]) env_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
        ram_dout <= env_mem[ram_addr];
    end

    // Reference model state: memory image, current owner and its run length, pending responses
    logic [31:0] ref_mem [1024];
    bit          ref_init = 1'b0;
    int          m_owner = -1, m_run = 0, m_lastown = 1;
    logic [9:0]  m_addr_hold = '0;
    bit          exp_rv [2];
    bit          exp_err [2];
    logic [31:0] exp_rd [2];

    // Compare DUT against the model each cycle, then advance the model by this cycle's access
    always @(negedge clk) begin
        int   w;
        req_t s;
        bit   lg;
        if (!ref_init) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (run_chk) begin
            if (rst) begin
                chk("rst_gnt0", 32'(m0_gnt), 0);
                chk("rst_gnt1", 32'(m1_gnt), 0);
                chk("rst_wren", 32'(ram_wren), 0);
                chk("rst_ben",  32'(ram_ben), 0);
                chk("rst_rv0",  32'(m0_rvalid), 0);
                chk("rst_rv1",  32'(m1_rvalid), 0);
                chk("rst_err0", 32'(m0_err), 0);
                chk("rst_err1", 32'(m1_err), 0);
                m_owner = -1; m_run = 0; m_lastown = 1; m_addr_hold = '0;
                for (int p = 0; p < 2; p++) begin exp_rv[p] = 0; exp_err[p] = 0; exp_rd[p] = '0; end
                exp_win = -1;
            end else begin
                chk("rvalid0", 32'(m0_rvalid), 32'(exp_rv[0]));
                chk("rvalid1", 32'(m1_rvalid), 32'(exp_rv[1]));
                chk("err0",    32'(m0_err),    32'(exp_err[0]));
                chk("err1",    32'(m1_err),    32'(exp_err[1]));
                chk("rdata0",  m0_rdata, exp_rd[0]);
                chk("rdata1",  m1_rdata, exp_rd[1]);

                if (req0 && !req1)      w = 0;
                else if (req1 && !req0) w = 1;
                else if (req0 && req1) begin
                    if (m_owner < 0) begin
`ifdef SRAM_ARB_RR_EN
                        w = 1 - m_lastown;
`else
                        w = 0;
`endif
                    end else if (m_run < MAX_HOLD) w = m_owner;
                    else                           w = 1 - m_owner;
                end else w = -1;

                s  = (w == 1) ? cur1 : cur0;
                lg = is_legal(s.ben);
                chk("gnt0", 32'(m0_gnt), 32'(w == 0));
                chk("gnt1", 32'(m1_gnt), 32'(w == 1));
                chk("ram_wren", 32'(ram_wren), 32'(w >= 0 && lg && s.wr));
                chk("ram_ben",  32'(ram_ben),  (w >= 0 && lg) ? 32'(s.ben) : 32'd0);
                chk("ram_addr", 32'(ram_addr), (w >= 0) ? 32'(s.addr) : 32'(m_addr_hold));
                if (w >= 0 && lg && s.wr) chk("ram_din", ram_din, s.wdata);

                for (int p = 0; p < 2; p++) begin exp_rv[p] = 0; exp_err[p] = 0; end
                if (w >= 0) begin
                    if (!lg) exp_err[w] = 1'b1;
                    else if (!s.wr) begin
                        exp_rv[w] = 1'b1;
                        exp_rd[w] = ref_mem[s.addr] & lanes(s.ben);
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (s.ben[b]) ref_mem[s.addr][b*8 +: 8] = s.wdata[b*8 +: 8];
                    end
                    m_run       = (w == m_owner) ? ((m_run < MAX_HOLD) ? m_run + 1 : m_run) : 1;
                    m_owner     = w;
                    m_lastown   = w;
                    m_addr_hold = s.addr;
                end else begin
                    m_owner = -1;
                    m_run   = 0;
                end
                exp_win = w;
            end
        end
    end

    // Requesters: hold each request until granted, then take the next from queue or random source
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!req0 || exp_win == 0) begin
                if (q0.size() > 0)                                  begin cur0 = q0.pop_front(); req0 = 1'b1; end
                else if (rand_en && $urandom_range(0, 2) != 0)      begin cur0 = rand_req();     req0 = 1'b1; end
                else req0 = 1'b0;
            end
            if (!req1 || exp_win == 1) begin
                if (q1.size() > 0)                                  begin cur1 = q1.pop_front(); req1 = 1'b1; end
                else if (rand_en && $urandom_range(0, 2) != 0)      begin cur1 = rand_req();     req1 = 1'b1; end
                else req1 = 1'b0;
            end
        end
    end

    // Wait (bounded) for a DUT event: 0=m0_rvalid 1=m1_rvalid 2=m0_err 3=m1_gnt
    task automatic wait_evt(input int which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((which == 0 && m0_rvalid) || (which == 1 && m1_rvalid) ||
                (which == 2 && m0_err)    || (which == 3 && m1_gnt)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int log_w[$];
        int pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int first_w;

        @(posedge clk);
        run_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write then read back on port 0
        q0.push_back('{1'b1, 10'h005, 32'hDEAD_BEEF, 4'b1111});
        q0.push_back('{1'b0, 10'h005, 32'h0, 4'b1111});
        wait_evt(0, seen);
        chk("t1_rv_seen", 32'(seen), 1);
        chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_model_mem", ref_mem[5], 32'hDEAD_BEEF);

        // Single-lane read on port 1
        q1.push_back('{1'b0, 10'h005, 32'h0, 4'b0010});
        wait_evt(1, seen);
        chk("t2_rv_seen", 32'(seen), 1);
        chk("t2_rdata", m1_rdata, 32'h0000_BE00);
        repeat (3) @(negedge clk);

        // Continuous contention: hold budget bounds each ownership run
        for (int i = 0; i < 5; i++) q0.push_back('{1'b0, 10'(i), 32'h0, 4'b1111});
        for (int i = 0; i < 4; i++) q1.push_back('{1'b0, 10'(i + 8), 32'h0, 4'b1111});
        for (int i = 0; i < 40 && log_w.size() < 9; i++) begin
            @(negedge clk);
            if (m0_gnt) log_w.push_back(0);
            else if (m1_gnt) log_w.push_back(1);
        end
        chk("t3_count", 32'(log_w.size()), 9);
        for (int i = 0; i < 9 && i < log_w.size(); i++) chk("t3_pattern", 32'(log_w[i]), 32'(pat[i]));
        repeat (3) @(negedge clk);

        // Tie from IDLE after port 0 was the last owner
        q0.push_back('{1'b0, 10'h001, 32'h0, 4'b1111});
        q1.push_back('{1'b0, 10'h002, 32'h0, 4'b1111});
        first_w = -1;
        for (int i = 0; i < 20 && first_w < 0; i++) begin
            @(negedge clk);
            if (m0_gnt) first_w = 0;
            else if (m1_gnt) first_w = 1;
        end
`ifdef SRAM_ARB_RR_EN
        chk("t4_idle_tie", 32'(first_w), 1);
`else
        chk("t4_idle_tie", 32'(first_w), 0);
`endif
        repeat (4) @(negedge clk);

        // Illegal byte enable: consumed, error pulse, memory untouched
        q0.push_back('{1'b1, 10'h010, 32'h1234_5678, 4'b0101});
        wait_evt(2, seen);
        chk("t5_err_seen", 32'(seen), 1);
        q0.push_back('{1'b0, 10'h010, 32'h0, 4'b1111});
        wait_evt(0, seen);
        chk("t5_rv_seen", 32'(seen), 1);
        chk("t5_rdata", m0_rdata, 32'h1000_0010);
        repeat (2) @(negedge clk);

        // Reset right after a port 1 read grant drops the response
        q1.push_back('{1'b0, 10'h005, 32'h0, 4'b1111});
        wait_evt(3, seen);
        chk("t6_gnt_seen", 32'(seen), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_rv1_in_rst", 32'(m1_rvalid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rv1_after", 32'(m1_rvalid), 0);
        chk("t6_rdata1_after", m1_rdata, 32'h0);
        chk("t6_addr_after", 32'(ram_addr), 0);

        // Randomized traffic with occasional resets
        rand_en = 1'b1;
        repeat (4000) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        rand_en = 1'b0;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
